// File: rtl/uart_tsr_tx.sv
// UART transmit shift register and framing FSM: pulls a byte from the TX buffer and
// serialises start/data/parity/stop onto txd. Optional macro UART_TX_BREAK_EN enables bc.
//
// state  | meaning
// IDLE   | no frame in flight, txd=1, loads as soon as the buffer is non-empty
// START  | start bit (txd=0) for OSR ticks
// DATA   | 5..8 data bits, LSB first
// PARITY | parity bit, only when pen was set at load
// STOP   | 1, 1.5 or 2 stop bits; the final tick may chain straight into START
module uart_tsr_tx #(
  parameter int OSR     = 16,
  parameter int OSR_LOG = 4
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_empty,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       bc,
  output logic       tsr_load,
  output logic       txd,
  output logic       tsr_empty
);

  localparam int TW = OSR_LOG + 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(OSR - 1);
  localparam logic [TW-1:0] STOP1_LAST = TW'(OSR - 1);
  localparam logic [TW-1:0] STOP2_LAST = TW'(2 * OSR - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'((3 * OSR) / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      last_bit_q, last_bit_d;
  logic            pen_q, pen_d;
  logic            par_q, par_d;
  logic [TW-1:0]   stop_last_q, stop_last_d;
  logic            txd_q, txd_d;
  logic            load;
  logic            tick_end;
  logic            txd_fsm;
  logic [7:0]      mask;

  assign mask     = 8'hFF >> (2'd3 - wls);
  assign tick_end = (state_q == STOP) ? (tick_q == stop_last_q) : (tick_q == BIT_LAST);

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    last_bit_d  = last_bit_q;
    pen_d       = pen_q;
    par_d       = par_q;
    stop_last_d = stop_last_q;
    load        = 1'b0;
    txd_fsm     = 1'b1;
    txd_d       = 1'b1;

    case (state_q)
      IDLE: load = ~tx_empty;
      START: begin
        if (baud_tick) begin
          if (tick_end) begin
            state_d = DATA;
            tick_d  = '0;
            bit_d   = '0;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (tick_end) begin
            tick_d = '0;
            if (bit_q == last_bit_q) begin
              state_d = pen_q ? PARITY : STOP;
            end else begin
              bit_d   = bit_q + 3'd1;
              shift_d = shift_q >> 1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          if (tick_end) begin
            state_d = STOP;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (tick_end) begin
            load    = ~tx_empty;
            state_d = IDLE;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset holds the load strobe low even though IDLE is already reached.
    if (!presetn) load = 1'b0;

    if (load) begin
      state_d     = START;
      tick_d      = '0;
      bit_d       = '0;
      shift_d     = tx_data;
      last_bit_d  = 3'd4 + {1'b0, wls};
      pen_d       = pen;
      par_d       = sp ? ~eps : ((^(tx_data & mask)) ^ ~eps);
      stop_last_d = !stb ? STOP1_LAST : ((wls == 2'b00) ? STOP15_LAST : STOP2_LAST);
    end

    case (state_d)
      START:   txd_fsm = 1'b0;
      DATA:    txd_fsm = shift_d[0];
      PARITY:  txd_fsm = par_d;
      default: txd_fsm = 1'b1;
    endcase

`ifdef UART_TX_BREAK_EN
    txd_d = bc ? 1'b0 : txd_fsm;
`else
    txd_d = txd_fsm;
`endif
  end

`ifndef UART_TX_BREAK_EN
  logic unused_bc;
  assign unused_bc = bc;
`endif

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      last_bit_q  <= '0;
      pen_q       <= 1'b0;
      par_q       <= 1'b0;
      stop_last_q <= '0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      last_bit_q  <= last_bit_d;
      pen_q       <= pen_d;
      par_q       <= par_d;
      stop_last_q <= stop_last_d;
      txd_q       <= txd_d;
    end
  end

  assign tsr_load  = load;
  assign txd       = txd_q;
  assign tsr_empty = (state_q == IDLE);

endmodule

// File: tb/tb_uart_tsr_tx.sv
// Self-checking bench for uart_tsr_tx: per-tick txd waveform model built from the frame rules.
module tb_uart_tsr_tx;
  localparam int OSR = 16;
`ifdef UART_TX_BREAK_EN
  localparam bit BRK = 1'b1;
`else
  localparam bit BRK = 1'b0;
`endif

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_empty = 1'b1;
  logic [1:0] wls = 2'b00;
  logic       stb = 1'b0, pen = 1'b0, eps = 1'b0, sp = 1'b0, bc = 1'b0;
  logic       tsr_load, txd, tsr_empty;

  uart_tsr_tx #(.OSR(OSR), .OSR_LOG(4)) dut (
    .pclk(pclk), .presetn(presetn), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_empty(tx_empty), .wls(wls), .stb(stb), .pen(pen), .eps(eps), .sp(sp), .bc(bc),
    .tsr_load(tsr_load), .txd(txd), .tsr_empty(tsr_empty)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [7:0] d;
    logic [1:0] wls;
    logic stb, pen, eps, sp;
    int bs, be;
  } frame_t;

  int     errors = 0;
  int     checks = 0;
  logic   ld_seen;
  frame_t fq[$];
  logic   lv[$];

  task automatic step(input logic bt);
    baud_tick = bt;
    @(negedge pclk);
    ld_seen = tsr_load;
    @(posedge pclk);
    #1;
    baud_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected txd level for every baud tick of the frame.
  task automatic build(input frame_t f);
    int n, ones, nstop;
    logic p;
    lv.delete();
    repeat (OSR) lv.push_back(1'b0);
    n = 5 + int'(f.wls);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      ones += int'(f.d[i]);
      repeat (OSR) lv.push_back(f.d[i]);
    end
    if (f.pen) begin
      if (f.sp) p = ~f.eps;
      else p = f.eps ? logic'(ones % 2) : logic'((ones + 1) % 2);
      repeat (OSR) lv.push_back(p);
    end
    nstop = !f.stb ? OSR : ((f.wls == 2'b00) ? (3 * OSR) / 2 : 2 * OSR);
    repeat (nstop) lv.push_back(1'b1);
  endtask

  task automatic apply(input frame_t f);
    tx_data = f.d; wls = f.wls; stb = f.stb; pen = f.pen; eps = f.eps; sp = f.sp;
    tx_empty = 1'b0;
  endtask

  task automatic scramble();
    tx_data = 8'($urandom); wls = 2'($urandom); stb = 1'($urandom);
    pen = 1'($urandom); eps = 1'($urandom); sp = 1'($urandom);
    tx_empty = 1'b1;
  endtask

  task automatic play();
    frame_t f;
    bit more;
    int L;
    apply(fq[0]);
    step(1'b0);
    chk("load_first", ld_seen, 1'b1);
    for (int i = 0; i < fq.size(); i++) begin
      f = fq[i];
      build(f);
      L = lv.size();
      more = (i + 1 < fq.size());
      if (more) apply(fq[i + 1]); else scramble();
      chk($sformatf("start_txd f%0d", i), txd, lv[0]);
      chk($sformatf("busy_start f%0d", i), tsr_empty, 1'b0);
      for (int k = 1; k <= L; k++) begin
        bc = (k >= f.bs && k < f.be && k < L);
        repeat ($urandom_range(0, 2)) begin
          step(1'b0);
          chk("idle_noload", ld_seen, 1'b0);
        end
        step(1'b1);
        if (k < L) begin
          chk("noload", ld_seen, 1'b0);
          chk($sformatf("txd f%0d k%0d", i, k), txd, (BRK && bc) ? 1'b0 : lv[k]);
          chk("busy", tsr_empty, 1'b0);
        end else begin
          chk($sformatf("eof_load f%0d", i), ld_seen, more);
        end
      end
    end
    bc = 1'b0;
    chk("end_txd", txd, 1'b1);
    chk("end_empty", tsr_empty, 1'b1);
    step(1'b0);
    chk("end_noload", ld_seen, 1'b0);
    fq.delete();
  endtask

  function automatic frame_t rnd_frame();
    frame_t f;
    f.d = 8'($urandom); f.wls = 2'($urandom); f.stb = 1'($urandom);
    f.pen = 1'($urandom); f.eps = 1'($urandom); f.sp = 1'($urandom);
    f.bs = int'($urandom_range(1, 150));
    f.be = ($urandom_range(0, 1) == 0) ? 0 : f.bs + int'($urandom_range(1, 40));
    return f;
  endfunction

  initial begin
    // Reset and idle with empty buffer
    presetn = 1'b0;
    repeat (3) step(1'b0);
    chk("rst_txd", txd, 1'b1);
    chk("rst_empty", tsr_empty, 1'b1);
    chk("rst_load", ld_seen, 1'b0);
    presetn = 1'b1;
    repeat (100) begin
      step(1'b1);
      chk("idle_txd", txd, 1'b1);
      chk("idle_load", ld_seen, 1'b0);
      chk("idle_empty", tsr_empty, 1'b1);
    end

    // 8N1 0xA5
    fq.push_back('{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0});
    play();

    // 5 bits even parity, 1.5 stop
    fq.push_back('{8'h1F, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0});
    play();

    // Back-to-back, stick parity
    fq.push_back('{8'h55, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0});
    fq.push_back('{8'h0F, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0});
    play();

    // Reset during data bit 3 of 0xFF
    apply('{8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0});
    step(1'b0);
    chk("r5_load", ld_seen, 1'b1);
    repeat (OSR + 3 * OSR + 8) step(1'b1);
    chk("r5_bit3", txd, 1'b1);
    chk("r5_busy", tsr_empty, 1'b0);
    presetn = 1'b0;
    step(1'b0);
    chk("r5_rst_txd", txd, 1'b1);
    chk("r5_rst_empty", tsr_empty, 1'b1);
    chk("r5_rst_load", ld_seen, 1'b0);
    step(1'b1);
    chk("r5_rst_load2", ld_seen, 1'b0);
    fq.push_back('{8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0});
    presetn = 1'b1;
    play();

    // Break window mid-frame (ignored when the feature is compiled out)
    fq.push_back('{8'h3C, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 20, 60});
    play();

    // Randomised sequences of 1..3 frames
    for (int s = 0; s < 10; s++) begin
      int nf;
      nf = int'($urandom_range(1, 3));
      for (int j = 0; j < nf; j++) fq.push_back(rnd_frame());
      play();
      repeat ($urandom_range(0, 5)) begin
        step(1'($urandom));
        chk("gap_load", ld_seen, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
